pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB. It also sequences exception/ERET flushes, including deferral while the data memory is busy. It keeps a stall-cycle performance counter and a stall watchdog.

---
 rtl/pipe_stall_ctrl_if.sv | 38 +++
 rtl/pipe_stall_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush sequencer.
// The master modport belongs to the pipeline side: it raises stall requests and
// exception reports, and it consumes the stall vector, flush, redirect and status.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  // Per-stage stall requests
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;

  // Exception / ERET report from MEM
  logic             excp_valid;
  logic             excp_eret;
  logic [31:0]      excp_epc;

  // Sequencer outputs
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic             wdog_trip;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_eret, excp_epc,
    input  stall, flush, new_pc, stall_cycles, wdog_trip
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_eret, excp_epc,
    output stall, flush, new_pc, stall_cycles, wdog_trip
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges stage stall requests into a 6-bit freeze vector (bit0 = PC .. bit5 = WB),
// sequences exception/ERET flushes (deferring while MEM is busy), and keeps a
// saturating stall-cycle counter plus a sticky stall watchdog.
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  // Run counter only has to reach WDOG_LIMIT, then it saturates there.
  localparam int unsigned     RunW     = $clog2(WDOG_LIMIT + 1);
  localparam logic [RunW-1:0] RunLimit = RunW'(WDOG_LIMIT);

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = 6'b111111;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StFreeze,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic             eret_q, eret_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             trip_q, trip_d;

  logic [5:0]       req_stall;
  logic [5:0]       stall;
  logic             flush;
  logic             capture;

  // Merge stage requests: the deepest requesting stage decides how far the freeze reaches.
  always_comb begin
    req_stall = StallNone;
    if (bus.stallreq_mem) begin
      req_stall = StallMem;
    end else if (bus.stallreq_ex) begin
      req_stall = StallEx;
    end else if (bus.stallreq_id) begin
      req_stall = StallId;
    end else if (bus.stallreq_if) begin
      req_stall = StallIf;
    end
  end

  // Flush sequencer next state, plus the state-defined stall/flush outputs.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    stall   = StallNone;
    flush   = 1'b0;
    case (state_q)
      StIdle: begin
        stall = req_stall;
        if (bus.excp_valid) begin
          capture = 1'b1;
          if (bus.stallreq_mem) begin
            // MEM access in flight must complete before the pipe can be frozen whole.
            state_d = StWaitMem;
            stall   = StallMem;
          end else begin
            state_d = StFreeze;
            stall   = StallAll;
          end
        end
      end
      StWaitMem: begin
        stall = StallMem;
        if (!bus.stallreq_mem) begin
          state_d = StFreeze;
        end
      end
      StFreeze: begin
        stall   = StallAll;
        state_d = StFlush;
      end
      StFlush: begin
        flush   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Nothing is frozen or flushed while reset is held.
    if (reset) begin
      stall = StallNone;
      flush = 1'b0;
    end
  end

  // Capture the exception kind/EPC; redirect target is resolved on entry to FLUSH.
  always_comb begin
    eret_d   = eret_q;
    epc_d    = epc_q;
    new_pc_d = new_pc_q;
    if (capture) begin
      eret_d = bus.excp_eret;
      epc_d  = bus.excp_epc;
    end
    if (state_q == StFreeze) begin
      new_pc_d = eret_q ? epc_q : EXC_VECTOR;
    end
  end

  // Stall performance counter and watchdog run counter, both saturating.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    trip_d = trip_q;
    if (stall[0] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!stall[0]) begin
      run_d = '0;
    end else if (run_q != RunLimit) begin
      run_d = run_q + RunW'(1);
    end
    if (run_q == RunLimit) begin
      trip_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      eret_q   <= 1'b0;
      epc_q    <= '0;
      new_pc_q <= '0;
      cnt_q    <= '0;
      run_q    <= '0;
      trip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      eret_q   <= eret_d;
      epc_q    <= epc_d;
      new_pc_q <= new_pc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      trip_q   <= trip_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.flush        = flush;
  assign bus.new_pc       = new_pc_q;
  assign bus.stall_cycles = cnt_q;
  assign bus.wdog_trip    = trip_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: priority encoding, exception and deferred
// ERET sequencing, counters, watchdog, mid-sequence reset and counter saturation.
module tb_pipe_stall_ctrl;

  localparam int unsigned CntW  = 4;
  localparam int unsigned WLim  = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_stall_ctrl #(
    .EXC_VECTOR (32'hBFC0_0380),
    .WDOG_LIMIT (WLim),
    .CNT_W      (CntW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.excp_valid   = 1'b0;
    bus.excp_eret    = 1'b0;
    bus.excp_epc     = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'h00);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_cnt", 32'(bus.stall_cycles), 32'h0);
    chk("rst_wdog", 32'(bus.wdog_trip), 32'h0);

    // Priority encoding
    bus.stallreq_if = 1'b1; bus.stallreq_id = 1'b1; bus.stallreq_mem = 1'b1;
    #1 chk("prio_mem", 32'(bus.stall), 32'h1F);
    tick();
    bus.stallreq_mem = 1'b0;
    #1 chk("prio_id", 32'(bus.stall), 32'h07);
    tick();
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
    #1 chk("prio_none", 32'(bus.stall), 32'h00);
    chk("prio_cnt", 32'(bus.stall_cycles), 32'd2);
    bus.stallreq_ex = 1'b1;
    #1 chk("prio_ex", 32'(bus.stall), 32'h0F);
    bus.stallreq_ex = 1'b0; bus.stallreq_if = 1'b1;
    #1 chk("prio_if", 32'(bus.stall), 32'h03);
    bus.stallreq_if = 1'b0;
    tick();

    // Exception with no mem stall: cycle N
    bus.excp_valid = 1'b1; bus.excp_eret = 1'b0;
    #1 chk("exc_n_stall", 32'(bus.stall), 32'h3F);
    chk("exc_n_flush", 32'(bus.flush), 32'h0);
    tick();
    bus.excp_valid = 1'b0;
    #1 chk("exc_n1_stall", 32'(bus.stall), 32'h3F);
    chk("exc_n1_flush", 32'(bus.flush), 32'h0);
    tick();
    chk("exc_n2_flush", 32'(bus.flush), 32'h1);
    chk("exc_n2_stall", 32'(bus.stall), 32'h00);
    chk("exc_n2_pc", bus.new_pc, 32'hBFC0_0380);
    tick();
    chk("exc_n3_flush", 32'(bus.flush), 32'h0);
    chk("exc_n3_pc_hold", bus.new_pc, 32'hBFC0_0380);
    chk("exc_cnt", 32'(bus.stall_cycles), 32'd4);

    // Deferred ERET while MEM busy; second pulse during wait must be dropped
    bus.stallreq_mem = 1'b1; bus.excp_valid = 1'b1; bus.excp_eret = 1'b1;
    bus.excp_epc = 32'h8000_1234;
    #1 chk("eret_cap_stall", 32'(bus.stall), 32'h1F);
    tick();
    bus.excp_eret = 1'b0; bus.excp_epc = 32'hDEAD_BEEF;
    #1 chk("eret_w1_stall", 32'(bus.stall), 32'h1F);
    tick();
    bus.excp_valid = 1'b0;
    #1 chk("eret_w2_stall", 32'(bus.stall), 32'h1F);
    tick();
    chk("eret_w3_stall", 32'(bus.stall), 32'h1F);
    tick();
    bus.stallreq_mem = 1'b0;
    #1 chk("eret_w4_stall", 32'(bus.stall), 32'h1F);
    chk("eret_w4_flush", 32'(bus.flush), 32'h0);
    tick();
    chk("eret_frz_stall", 32'(bus.stall), 32'h3F);
    chk("eret_frz_flush", 32'(bus.flush), 32'h0);
    tick();
    chk("eret_flush", 32'(bus.flush), 32'h1);
    chk("eret_pc", bus.new_pc, 32'h8000_1234);
    tick();
    chk("eret_idle_flush", 32'(bus.flush), 32'h0);
    chk("eret_cnt", 32'(bus.stall_cycles), 32'd10);
    chk("eret_wdog", 32'(bus.wdog_trip), 32'h1);

    // Counters and watchdog from a clean reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("cnt_rst_cnt", 32'(bus.stall_cycles), 32'h0);
    chk("cnt_rst_wdog", 32'(bus.wdog_trip), 32'h0);
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("wdog_pre", 32'(bus.wdog_trip), 32'h0);
    tick();
    bus.stallreq_ex = 1'b0;
    #1 chk("cnt_five", 32'(bus.stall_cycles), 32'd5);
    chk("wdog_set", 32'(bus.wdog_trip), 32'h1);
    tick();
    chk("wdog_sticky", 32'(bus.wdog_trip), 32'h1);
    chk("cnt_hold", 32'(bus.stall_cycles), 32'd5);

    // Reset while in WAIT_MEM
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.stallreq_mem = 1'b1; bus.excp_valid = 1'b1; bus.excp_eret = 1'b1;
    bus.excp_epc = 32'h1234_5678;
    tick();
    bus.excp_valid = 1'b0; bus.stallreq_mem = 1'b0;
    #1 chk("rwm_wait_stall", 32'(bus.stall), 32'h1F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("rwm_stall", 32'(bus.stall), 32'h00);
    chk("rwm_flush", 32'(bus.flush), 32'h0);
    chk("rwm_cnt", 32'(bus.stall_cycles), 32'h0);
    chk("rwm_pc", bus.new_pc, 32'h0);
    tick();
    chk("rwm_flush_1", 32'(bus.flush), 32'h0);
    tick();
    chk("rwm_flush_2", 32'(bus.flush), 32'h0);
    chk("rwm_pc_2", bus.new_pc, 32'h0);

    // Saturation of the 4-bit counter
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(bus.stall_cycles), 32'hE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_20", 32'(bus.stall_cycles), 32'hF);
    bus.stallreq_ex = 1'b0;
    tick();
    chk("sat_hold", 32'(bus.stall_cycles), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
